// File: rtl/piano_cmd_tx.sv
// piano_cmd_tx: serializes {key,vel} commands MSB first to a piano shift-register receiver.
// Define PIANO_CMD_TX_FIFO_EN for a 4-entry command FIFO; otherwise a single holding register.
module piano_cmd_tx #(
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int GAP_CYCLES   = 280,
    parameter int NUM_KEYS     = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_key,
    input  logic [6:0] cmd_vel,
    output logic       clk_sr,
    output logic       d,
    output logic       latch,
    output logic       busy,
    output logic       key_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] LAT_LAST = 16'(LATCH_CYCLES - 1);
    // GAP lasts one cycle less than GAP_CYCLES; the IDLE cycle that pops the next word completes the gap
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 2);
    localparam logic [7:0]  NK       = 8'(NUM_KEYS);

    state_t      state_q;
    logic        rdy_q, key_err_q, clk_sr_q, d_q, latch_q, ph_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] cnt_q;
    logic [13:0] sr_q;
    logic        buf_full, buf_empty, pop, push, accept, key_bad;
    logic [13:0] buf_word;

    assign pop       = (state_q == IDLE) && !buf_empty;
    assign cmd_ready = rdy_q && (!buf_full || pop);
    assign accept    = cmd_valid && cmd_ready;
    assign key_bad   = {1'b0, cmd_key} >= NK;
    assign push      = accept && !key_bad;

`ifdef PIANO_CMD_TX_FIFO_EN
    logic [13:0] mem_q [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  fcnt_q, fcnt_d;

    assign fcnt_d    = fcnt_q + {2'b0, push} - {2'b0, pop};
    assign buf_full  = fcnt_q == 3'd4;
    assign buf_empty = fcnt_q == 3'd0;
    assign buf_word  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {cmd_key, cmd_vel};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            wp_q   <= push ? wp_q + 2'd1 : wp_q;
            rp_q   <= pop ? rp_q + 2'd1 : rp_q;
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic [13:0] hold_q;
    logic        full_q, full_d;

    assign full_d    = push || (full_q && !pop);
    assign buf_full  = full_q;
    assign buf_empty = !full_q;
    assign buf_word  = hold_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= push ? {cmd_key, cmd_vel} : hold_q;
            full_q <= full_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            key_err_q <= 1'b0;
            clk_sr_q  <= 1'b0;
            d_q       <= 1'b0;
            latch_q   <= 1'b0;
            ph_q      <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
        end else begin
            rdy_q     <= 1'b1;
            key_err_q <= accept && key_bad;
            case (state_q)
                IDLE: if (!buf_empty) begin
                    state_q  <= SHIFT;
                    sr_q     <= buf_word;
                    d_q      <= buf_word[13];
                    bit_q    <= 4'd13;
                    div_q    <= '0;
                    ph_q     <= 1'b0;
                    clk_sr_q <= 1'b0;
                end
                SHIFT: if (div_q == DIV_LAST) begin
                    div_q <= '0;
                    if (!ph_q) begin
                        ph_q     <= 1'b1;
                        clk_sr_q <= 1'b1;
                    end else if (bit_q == 4'd0) begin
                        state_q  <= LATCH;
                        ph_q     <= 1'b0;
                        clk_sr_q <= 1'b0;
                        d_q      <= 1'b0;
                        latch_q  <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        bit_q    <= bit_q - 4'd1;
                        ph_q     <= 1'b0;
                        clk_sr_q <= 1'b0;
                        d_q      <= sr_q[bit_q - 4'd1];
                    end
                end else begin
                    div_q <= div_q + 8'd1;
                end
                LATCH: if (cnt_q == LAT_LAST) begin
                    latch_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= (GAP_CYCLES > 1) ? GAP : IDLE;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                GAP: if (cnt_q == GAP_LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_sr  = clk_sr_q;
    assign d       = d_q;
    assign latch   = latch_q;
    assign key_err = key_err_q;
    assign busy    = (state_q != IDLE) || !buf_empty;
endmodule

// File: tb/tb_piano_cmd_tx.sv
// tb_piano_cmd_tx: scoreboard bench; stimulus queues expected words, a negedge monitor reassembles and compares them.
module tb_piano_cmd_tx;
    localparam int CD = 4, LC = 2, GC = 280, NK = 12;
    localparam int PERIOD = 28 * CD + LC + GC;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
    logic [6:0] cmd_key = '0, cmd_vel = '0;
    logic       cmd_ready, clk_sr, d, latch, busy, key_err;

    int cyc = 0, checks = 0, errors = 0;
    int rise_total = 0, latch_total = 0, kerr_total = 0, kerr_exp = 0;
    int first_rise = 0, nbits = 0, last_rise = 0, lat_start = 0;
    logic [13:0] exp_q[$];
    int lat_q[$], fall_q[$], fr_q[$];
    logic [13:0] word = '0;
    logic p_clk = 1'b0, p_lat = 1'b0, p_kerr = 1'b0;

    piano_cmd_tx #(.CLK_DIV(CD), .LATCH_CYCLES(LC), .GAP_CYCLES(GC), .NUM_KEYS(NK)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_vel(cmd_vel), .clk_sr(clk_sr), .d(d),
        .latch(latch), .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] k, input logic [6:0] v, input logic [13:0] w, output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_key   = k;
        cmd_vel   = v;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout key %0d: ready %0b expected 1", k, cmd_ready);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        if (k >= NK) kerr_exp++;
        else exp_q.push_back(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %0b expected 0", busy);
        end
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits  = 0;
            word   = '0;
            p_clk  = 1'b0;
            p_lat  = 1'b0;
            p_kerr = 1'b0;
        end else begin
            if (clk_sr && !p_clk) begin
                if (nbits > 0) chk("bit_spacing", cyc - last_rise, 2 * CD);
                else begin
                    first_rise = cyc;
                    fr_q.push_back(cyc);
                end
                nbits++;
                word = {word[12:0], d};
                last_rise = cyc;
                rise_total++;
            end
            if (latch && !p_lat) begin
                lat_start = cyc;
                latch_total++;
                lat_q.push_back(cyc);
                chk("latch_after_bit0", cyc - last_rise, CD);
                chk("bit_count", nbits, 14);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", word);
                end else chk("word", int'(word), int'(exp_q.pop_front()));
                nbits = 0;
                word  = '0;
            end
            if (!latch && p_lat) begin
                chk("latch_width", cyc - lat_start, LC);
                fall_q.push_back(cyc);
            end
            if (key_err) begin
                kerr_total++;
                if (p_kerr) begin
                    checks++;
                    errors++;
                    $display("FAIL key_err_width: got >1 cycle expected 1");
                end
            end
            p_clk  = clk_sr;
            p_lat  = latch;
            p_kerr = key_err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, base;
        repeat (3) tick();
        chk("reset_outputs", int'({clk_sr, d, latch, busy, key_err, cmd_ready}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("ready_before_release_edge", cmd_ready, 0);
        tick();
        chk("ready_after_reset", cmd_ready, 1);
        chk("busy_after_reset", busy, 0);

        send(7'd5, 7'd100, 14'h02E4, a1);
        wait_idle();
        chk("first_bit_latency", first_rise - a1, 1 + CD);
        chk("single_word_latches", latch_total, 1);

        base = rise_total;
        send(7'd12, 7'd9, 14'h0000, a1);
        tick();
        chk("key_err_pulse", key_err, 1);
        tick();
        chk("key_err_clear", key_err, 0);
        repeat (20) tick();
        chk("bad_key_no_shift", rise_total - base, 0);
        chk("bad_key_busy", busy, 0);

        lat_q.delete();
        fall_q.delete();
        fr_q.delete();
        send(7'd11, 7'd127, 14'h05FF, a1);
        send(7'd0, 7'd0, 14'h0000, a2);
        chk("second_accept_delay", a2 - a1, 1);
        wait_idle();
        chk("b2b_word_count", lat_q.size(), 2);
        if (lat_q.size() >= 2 && fr_q.size() >= 2 && fall_q.size() >= 1) begin
            chk("word_period", lat_q[1] - lat_q[0], PERIOD);
            chk("gap_to_next_rise", fr_q[1] - fall_q[0], GC + CD);
        end

        base = latch_total;
        send(7'd3, 7'd85, 14'h01D5, a1);
        while (cyc < a1 + 1 + 12 * CD + 2) tick();
        chk("midword_bits", nbits, 6);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(exp_q.pop_back());
        chk("reset_midword_outputs", int'({clk_sr, d, latch, busy, key_err, cmd_ready}), 0);
        @(posedge clk);
        #1;
        chk("ready_after_midword_reset", cmd_ready, 1);
        send(7'd7, 7'd42, 14'h03AA, a1);
        wait_idle();
        chk("no_latch_on_abort", latch_total - base, 1);

        send(7'd127, 7'd5, 14'h0000, a1);
        send(7'd1, 7'd1, 14'h0081, a2);
        chk("bad_key_not_buffered", a2 - a1, 1);
        wait_idle();

`ifdef PIANO_CMD_TX_FIFO_EN
        begin
            int acc[6];
            lat_q.delete();
            send(7'd5, 7'd100, 14'h02E4, acc[0]);
            send(7'd11, 7'd127, 14'h05FF, acc[1]);
            send(7'd0, 7'd0, 14'h0000, acc[2]);
            send(7'd3, 7'd85, 14'h01D5, acc[3]);
            send(7'd7, 7'd42, 14'h03AA, acc[4]);
            send(7'd10, 7'd64, 14'h0540, acc[5]);
            chk("fifo_burst_accept", acc[4] - acc[0], 4);
            chk("fifo_full_wait", acc[5] - acc[0], 1 + PERIOD);
            wait_idle();
            chk("fifo_word_count", lat_q.size(), 6);
        end
`endif

        chk("words_left", exp_q.size(), 0);
        chk("key_err_count", kerr_total, kerr_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
